// File: rtl/joypad_ctrl.sv
// joypad_ctrl: polls an NES-style serial pad and exposes buttons through a $4016-style strobe/shift register.
// Optional JOYPAD_DEBOUNCE_EN requires two identical consecutive polls before buttons change.
module joypad_ctrl #(
    parameter int CLK_DIV     = 150,
    parameter int POLL_CYCLES = 833333
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pad_latch,
    output logic       pad_clk,
    input  logic       pad_data,
    output logic [7:0] buttons,
    output logic       buttons_valid,
    input  logic       cpu_sel,
    input  logic       cpu_rd,
    input  logic       cpu_wr,
    input  logic       cpu_wdata,
    output logic       cpu_rdata
);
    localparam int PW = $clog2(POLL_CYCLES);
    localparam int TW = $clog2(2 * CLK_DIV);
    localparam logic [TW-1:0] LAST_LATCH = TW'(2 * CLK_DIV - 1);
    localparam logic [TW-1:0] LAST_HALF  = TW'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, LATCH, CLKH, CLKL, DONE} state_t;

    state_t        state;
    logic [1:0]    sync;
    logic          d_s;
    logic [PW-1:0] cnt;
    logic          wrap;
    logic [TW-1:0] tmr;
    logic [2:0]    idx;
    logic [7:0]    raw;
    logic          strobe;
    logic [7:0]    shift;
    logic          wr;
    logic          rd;
`ifdef JOYPAD_DEBOUNCE_EN
    logic [7:0]    cand;
`endif

    assign d_s       = ~sync[1];
    assign wrap      = cnt == PW'(POLL_CYCLES - 1);
    assign wr        = cpu_sel & cpu_wr;
    assign rd        = cpu_sel & cpu_rd;
    assign cpu_rdata = strobe ? buttons[0] : shift[0];

    // Idle pad line is high (not pressed), so the synchronizer resets to 1s.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b11;
            cnt  <= '0;
        end else begin
            sync <= {sync[0], pad_data};
            cnt  <= wrap ? '0 : cnt + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            tmr           <= '0;
            idx           <= '0;
            raw           <= '0;
            pad_latch     <= 1'b0;
            pad_clk       <= 1'b0;
            buttons       <= '0;
            buttons_valid <= 1'b0;
`ifdef JOYPAD_DEBOUNCE_EN
            cand          <= '0;
`endif
        end else begin
            buttons_valid <= 1'b0;
            case (state)
                IDLE: if (wrap) begin
                    state     <= LATCH;
                    pad_latch <= 1'b1;
                    tmr       <= '0;
                end
                LATCH: if (tmr == LAST_LATCH) begin
                    raw[0]    <= d_s;
                    idx       <= 3'd1;
                    tmr       <= '0;
                    pad_latch <= 1'b0;
                    pad_clk   <= 1'b1;
                    state     <= CLKH;
                end else tmr <= tmr + TW'(1);
                CLKH: if (tmr == LAST_HALF) begin
                    tmr     <= '0;
                    pad_clk <= 1'b0;
                    state   <= CLKL;
                end else tmr <= tmr + TW'(1);
                CLKL: if (tmr == LAST_HALF) begin
                    raw[idx] <= d_s;
                    tmr      <= '0;
                    if (idx == 3'd7) state <= DONE;
                    else begin
                        idx     <= idx + 3'd1;
                        pad_clk <= 1'b1;
                        state   <= CLKH;
                    end
                end else tmr <= tmr + TW'(1);
                DONE: begin
`ifdef JOYPAD_DEBOUNCE_EN
                    if (raw == cand) buttons <= raw;
                    else cand <= raw;
`else
                    buttons <= raw;
`endif
                    buttons_valid <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A write wins over a simultaneous read: the read still sees the old bit but does not shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe <= 1'b0;
            shift  <= '0;
        end else begin
            if (wr) strobe <= cpu_wdata;
            if (strobe) shift <= buttons;
            else if (rd && !wr) shift <= {1'b1, shift[7:1]};
        end
    end
endmodule
